rat_io_hub: RTL and testbench

RAT_IO_HUB -- requirements
Module: rat_io_hub

---
 rtl/rat_io_hub.sv | 123 ++++++++++++
 tb/tb_rat_io_hub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_io_hub.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rat_io_hub : port-mapped I/O hub for an 8-bit MCU (in/out ports, IRQ, clk-en)
// | Revision   : 1.0
// +----------------------------------------------------------------------------
module rat_io_hub #(
    parameter int         NUM_IN      = 4,
    parameter int         NUM_OUT     = 4,
    parameter int         NUM_IRQ     = 4,
    parameter logic [7:0] IN_BASE_ID  = 8'h20,
    parameter logic [7:0] OUT_BASE_ID = 8'h40,
    parameter logic [7:0] IRQ_MASK_ID = 8'hF0,
    parameter logic [7:0] IRQ_STAT_ID = 8'hF1,
    parameter int         CLK_DIV     = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    output logic                 CPU_CLK_EN,
    input  logic [7:0]           PORT_ID,
    input  logic [7:0]           OUT_PORT,
    input  logic                 IO_STRB,
    output logic [7:0]           IN_PORT,
    input  logic [8*NUM_IN-1:0]  IN_DATA,
    output logic [8*NUM_OUT-1:0] OUT_DATA,
    input  logic [NUM_IRQ-1:0]   IRQ_SRC,
    output logic                 INTERRUPT
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [7:0]         in_off;
    logic [7:0]         out_off;
    logic               hit_stat;
    logic               hit_mask;
    logic [NUM_OUT-1:0] hit_out;
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign CPU_CLK_EN = (div_cnt == DIV_LAST);

    // Offsets wrap modulo 256, so a base near 8'hFF still decodes contiguously.
    assign in_off   = PORT_ID - IN_BASE_ID;
    assign out_off  = PORT_ID - OUT_BASE_ID;
    assign hit_stat = (PORT_ID == IRQ_STAT_ID);
    assign hit_mask = (PORT_ID == IRQ_MASK_ID) && !hit_stat;

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
            logic [7:0] out_reg;

            assign hit_out[k] = (out_off == 8'(k)) && !hit_stat && !hit_mask;

            always_ff @(posedge CLK) begin
                if (!RESET_N) begin
                    out_reg <= '0;
                end else if (IO_STRB && hit_out[k]) begin
                    out_reg <= OUT_PORT;
                end
            end

            assign OUT_DATA[8*k +: 8] = out_reg;
        end
    endgenerate

    // Output-register IDs are write-only and shadow any overlapping input port.
    always_comb begin
        IN_PORT = 8'h00;
        if (hit_stat) begin
            IN_PORT = 8'(pending);
        end else if (hit_mask) begin
            IN_PORT = 8'(mask);
        end else if (!(|hit_out)) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (in_off == 8'(k)) begin
                    IN_PORT = IN_DATA[8*k +: 8];
                end
            end
        end
    end

    assign rise = sync2 & ~prev;
    assign clr  = (IO_STRB && hit_stat) ? OUT_PORT[NUM_IRQ-1:0] : '0;

    // A new edge is OR-ed in after the clear so that set wins on a collision.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            mask      <= '0;
            pending   <= '0;
            INTERRUPT <= 1'b0;
        end else begin
            sync1     <= IRQ_SRC;
            sync2     <= sync1;
            prev      <= sync2;
            if (IO_STRB && hit_mask) begin
                mask <= OUT_PORT[NUM_IRQ-1:0];
            end
            pending   <= (pending & ~clr) | rise;
            INTERRUPT <= |(pending & mask);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rat_io_hub.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_rat_io_hub : self-checking bench for rat_io_hub (CLK_DIV=3)
// | Revision      : 1.0
// +----------------------------------------------------------------------------
module tb_rat_io_hub;

    localparam int DIV = 3;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CPU_CLK_EN;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  IN_PORT;
    logic [31:0] IN_DATA;
    logic [31:0] OUT_DATA;
    logic [3:0]  IRQ_SRC;
    logic        INTERRUPT;

    rat_io_hub #(
        .NUM_IN(4), .NUM_OUT(4), .NUM_IRQ(4),
        .IN_BASE_ID(8'h20), .OUT_BASE_ID(8'h40),
        .IRQ_MASK_ID(8'hF0), .IRQ_STAT_ID(8'hF1),
        .CLK_DIV(DIV)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CPU_CLK_EN(CPU_CLK_EN),
        .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
        .IN_PORT(IN_PORT), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
        .IRQ_SRC(IRQ_SRC), .INTERRUPT(INTERRUPT)
    );

    always #5 CLK = ~CLK;

    int errs  = 0;
    int total = 0;

    // Reference state, valid after each modelled edge.
    logic [7:0] m_out [4];
    logic [3:0] m_mask, m_pend;
    logic       m_int;
    logic [3:0] m_hist [3];   // IRQ_SRC as sampled at the last three edges, newest first
    int         m_k;          // non-reset edges since reset
    bit         valid = 1'b0;

    typedef struct { logic [7:0] id; logic [7:0] exp; } rd_vec_t;
    typedef struct { logic [7:0] id; logic [7:0] data; logic [31:0] exp; } wr_vec_t;
    rd_vec_t    rd_tab [8];
    wr_vec_t    wr_tab [5];
    logic       en_pat [6];
    logic [7:0] ids [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] id);
        if (id == 8'hF1) return {4'h0, m_pend};
        if (id == 8'hF0) return {4'h0, m_mask};
        if (id >= 8'h40 && id < 8'h44) return 8'h00;
        if (id >= 8'h20 && id < 8'h24) return IN_DATA[(int'(id) - 32)*8 +: 8];
        return 8'h00;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] id, input logic [7:0] d,
                              input logic sb, input logic [3:0] irq);
        logic [3:0] rise, clr;
        logic       nint;
        if (!rn) begin
            for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
            for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
            m_mask = 4'h0; m_pend = 4'h0; m_int = 1'b0; m_k = 0; valid = 1'b1;
        end else begin
            // A request sampled high at edge n-2 and low at n-3 sets pending at edge n.
            rise = m_hist[1] & ~m_hist[2];
            clr  = 4'h0;
            nint = |(m_pend & m_mask);
            if (sb) begin
                if (id == 8'hF1)                    clr = d[3:0];
                else if (id == 8'hF0)               m_mask = d[3:0];
                else if (id >= 8'h40 && id < 8'h44) m_out[int'(id) - 64] = d;
            end
            m_pend    = (m_pend & ~clr) | rise;
            m_int     = nint;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = irq;
            m_k++;
        end
    endtask

    task automatic step(input logic rn, input logic [7:0] id, input logic [7:0] d,
                        input logic sb, input logic [3:0] irq);
        RESET_N = rn; PORT_ID = id; OUT_PORT = d; IO_STRB = sb; IRQ_SRC = irq;
        #1;
        if (valid) chk("in_port", {24'h0, IN_PORT}, {24'h0, model_read(id)});
        model_edge(rn, id, d, sb, irq);
        @(negedge CLK);
        if (valid) begin
            chk("out_data", OUT_DATA, {m_out[3], m_out[2], m_out[1], m_out[0]});
            chk("interrupt", {31'h0, INTERRUPT}, {31'h0, m_int});
            chk("cpu_clk_en", {31'h0, CPU_CLK_EN}, {31'h0, (m_k % DIV) == DIV - 1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] irq;
        logic [7:0] rid;
        rd_tab = '{'{8'h21, 8'h3C}, '{8'h20, 8'h11}, '{8'h23, 8'h44}, '{8'h22, 8'h33},
                   '{8'h99, 8'h00}, '{8'h24, 8'h00}, '{8'h1F, 8'h00}, '{8'hF0, 8'h00}};
        wr_tab = '{'{8'h42, 8'hA5, 32'h00A5_0000}, '{8'h50, 8'hFF, 32'h00A5_0000},
                   '{8'h40, 8'h11, 32'h00A5_0011}, '{8'h43, 8'hFF, 32'hFFA5_0011},
                   '{8'h44, 8'h77, 32'hFFA5_0011}};
        en_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ids    = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h41, 8'h42, 8'h43, 8'hF0, 8'hF1, 8'h99};
        IN_DATA = 32'h0;

        // Reset state and divider pattern after release.
        step(0, 8'h00, 8'h00, 0, 4'h0);
        step(0, 8'h00, 8'h00, 0, 4'h0);
        chk("rst_out_data", OUT_DATA, 32'h0);
        chk("rst_interrupt", {31'h0, INTERRUPT}, 32'h0);
        chk("en_pat0", {31'h0, CPU_CLK_EN}, {31'h0, en_pat[0]});
        for (int i = 1; i < 6; i++) begin
            step(1, 8'h00, 8'h00, 0, 4'h0);
            chk("en_pat", {31'h0, CPU_CLK_EN}, {31'h0, en_pat[i]});
        end

        for (int i = 0; i < 5; i++) begin
            step(1, wr_tab[i].id, wr_tab[i].data, 1, 4'h0);
            chk("wr_tab", OUT_DATA, wr_tab[i].exp);
        end

        IN_DATA = 32'h4433_3C11;
        for (int i = 0; i < 8; i++) begin
            step(1, rd_tab[i].id, 8'h00, 0, 4'h0);
            chk("rd_tab", {24'h0, IN_PORT}, {24'h0, rd_tab[i].exp});
        end

        // Masked IRQ pulse: pending after two edges, INTERRUPT one later, W1C clears.
        step(1, 8'hF0, 8'h02, 1, 4'h0);
        step(1, 8'h00, 8'h00, 0, 4'h2);
        step(1, 8'hF1, 8'h00, 0, 4'h0);
        chk("irq1_pend_early", {24'h0, IN_PORT}, 32'h0);
        step(1, 8'hF1, 8'h00, 0, 4'h0);
        chk("irq1_pend", {24'h0, IN_PORT}, 32'h02);
        chk("irq1_int_early", {31'h0, INTERRUPT}, 32'h0);
        step(1, 8'hF1, 8'h00, 0, 4'h0);
        chk("irq1_int", {31'h0, INTERRUPT}, 32'h1);
        step(1, 8'hF1, 8'h02, 1, 4'h0);
        chk("irq1_w1c", {24'h0, IN_PORT}, 32'h0);
        step(1, 8'hF1, 8'h00, 0, 4'h0);
        chk("irq1_int_clr", {31'h0, INTERRUPT}, 32'h0);

        // Unmasked pending, then mask enable, then set-beats-clear collision.
        step(1, 8'hF0, 8'h00, 1, 4'h0);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        step(1, 8'hF1, 8'h00, 0, 4'h1);
        chk("irq0_pend_nomask", {24'h0, IN_PORT}, 32'h01);
        chk("irq0_int_nomask", {31'h0, INTERRUPT}, 32'h0);
        step(1, 8'hF0, 8'h01, 1, 4'h1);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        chk("irq0_int_mask", {31'h0, INTERRUPT}, 32'h1);
        step(1, 8'h00, 8'h00, 0, 4'h0);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        step(1, 8'h00, 8'h00, 0, 4'h1);
        step(1, 8'hF1, 8'h01, 1, 4'h1);
        step(1, 8'hF1, 8'h00, 0, 4'h1);
        chk("set_beats_clr", {24'h0, IN_PORT}, 32'h01);
        step(1, 8'hF1, 8'h01, 1, 4'h1);
        step(1, 8'hF0, 8'h00, 1, 4'h0);

        // IRQ high through reset registers once; a held level does not re-set.
        step(0, 8'h00, 8'h00, 0, 4'h4);
        step(1, 8'hF1, 8'h00, 0, 4'h4);
        step(1, 8'hF1, 8'h00, 0, 4'h4);
        chk("rst_irq_early", {24'h0, IN_PORT}, 32'h0);
        step(1, 8'hF1, 8'h00, 0, 4'h4);
        chk("rst_irq_edge", {24'h0, IN_PORT}, 32'h04);
        step(1, 8'hF1, 8'h04, 1, 4'h4);
        for (int i = 0; i < 4; i++) step(1, 8'hF1, 8'h00, 0, 4'h4);
        chk("level_once", {24'h0, IN_PORT}, 32'h0);

        // Reset overrides a simultaneous write.
        step(1, 8'h41, 8'h5A, 1, 4'h0);
        step(1, 8'hF0, 8'h0F, 1, 4'h8);
        step(1, 8'h00, 8'h00, 0, 4'h8);
        step(1, 8'h00, 8'h00, 0, 4'h8);
        step(1, 8'h00, 8'h00, 0, 4'h8);
        chk("pre_rst_int", {31'h0, INTERRUPT}, 32'h1);
        step(0, 8'h42, 8'hFF, 1, 4'h8);
        chk("rst_wr_out", OUT_DATA, 32'h0);
        chk("rst_wr_int", {31'h0, INTERRUPT}, 32'h0);
        PORT_ID = 8'hF0; #1;
        chk("rst_wr_mask", {24'h0, IN_PORT}, 32'h0);
        PORT_ID = 8'hF1; #1;
        chk("rst_wr_pend", {24'h0, IN_PORT}, 32'h0);

        // Randomised traffic against the reference model.
        irq = 4'h8;
        for (int n = 0; n < 400; n++) begin
            IN_DATA = $urandom;
            irq = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            rid = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ids[$urandom_range(0, 10)];
            step(($urandom_range(0, 49) != 0), rid, 8'($urandom), 1'($urandom), irq);
        end

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
`default_nettype wire
